dcache_miss_initiator: RTL
==========================

# dcache_miss_initiator

Cache-side initiator for the dcache ↔ mem_ctrl block request/response protocol, placed inside core between the dcache miss logic and the core's dcache_mem_ctrl_* ports. It accepts one miss at a time from the dcache. If the victim block is dirty, it first issues a block write-back, then issues the refill read. It collects the latency-sensitive read response and hands the refilled block back to the dcache as a one-cycle fill pulse.

## Interface
- RESP_TIMEOUT, default 255: cycles to wait in RD_WAIT before re-issuing the read. Used only with DCACHE_MISS_TIMEOUT_EN; must be ≥ 1.
- clk  input  1  core clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-high
- miss_valid  input  1  dcache presents a miss
- miss_ready  output  1  block can accept a miss (IDLE only)
- miss_block_addr  input  main_mem_block_addr_t  block to refill
- miss_victim_dirty  input  1  victim needs write-back
- miss_victim_block_addr  input  main_mem_block_addr_t  victim address
- miss_victim_block_data  input  block_data_t  victim data
- req_valid  output  1  to dcache_mem_ctrl_req_valid
- req_type  output  req_type_t  READ=0, WRITE=1
- req_block_addr  output  main_mem_block_addr_t  request address
- req_block_data  output  block_data_t  write data; 0 for reads
- req_ready  input  1  from dcache_mem_ctrl_req_ready
- resp_valid  input  1  from dcache_mem_ctrl_resp_valid; no backpressure
- resp_block_data  input  block_data_t  read data
- fill_valid  output  1  one-cycle refill pulse to dcache
- fill_block_addr  output  main_mem_block_addr_t  refilled block address
- fill_block_data  output  block_data_t  refilled data
- err_timeout  output  1  sticky; set on any response timeout
- miss_count  output  32  saturating count of accepted misses
- wb_count  output  32  saturating count of write-backs issued

## Operation
- States: IDLE, WB_REQ, RD_REQ, RD_WAIT, FILL.
- IDLE: miss_ready=1. On miss_valid&&miss_ready, latch all miss_* inputs and increment miss_count. Next state is WB_REQ if dirty, else RD_REQ.
- WB_REQ: req_valid=1, req_type=WRITE, with the latched victim address/data. On req_ready, increment wb_count and go to RD_REQ. Writes are fire-and-forget; no response is expected.
- RD_REQ: req_valid=1, req_type=READ, req_block_addr=latched miss address. On req_ready, go to RD_WAIT.
- RD_WAIT: on resp_valid, capture resp_block_data and go to FILL.
- FILL: fill_valid=1 with the captured data and latched miss address, then go to IDLE.
- Outside RD_WAIT, resp_valid is ignored and its data is discarded. This covers stray or post-reset responses.
- Request fields are stable from the first cycle of req_valid until the handshake. req_valid never drops without req_ready.
- Counters saturate at 32'hFFFF_FFFF.
- A dirty victim whose address equals the miss address still performs write then read.

## Timing
- Reset (rst high at an edge): state=IDLE.
  - miss_ready=0 while rst is high.
  - req_valid=0, req_type=READ, req_block_addr=0, req_block_data=0.
  - fill_valid=0, fill_block_addr=0, fill_block_data=0.
  - err_timeout=0, miss_count=0, wb_count=0.
- Reset mid-operation abandons the miss with no fill. A later resp_valid in IDLE is ignored.
- miss_ready and req_valid are decoded from state, so there is no combinational path from miss_valid or req_ready.
- Clean miss, zero memory stall: accept at T, req_valid at T+1 (handshake at T+1), earliest resp_valid at T+2, fill_valid at T+3, miss_ready at T+4.
- Dirty miss: adds one WB_REQ cycle plus any req_ready stall.
- resp_valid arriving in the handshake cycle of RD_REQ is ignored. Responses are at least one cycle after the request handshake.

## Configuration
- DCACHE_MISS_TIMEOUT_EN defined:
  - A counter runs in RD_WAIT and clears on entry.
  - After RESP_TIMEOUT cycles with no resp_valid, set err_timeout and return to RD_REQ to re-issue the same read.
  - resp_valid in the same cycle the counter expires wins: go to FILL, no timeout.
- DCACHE_MISS_TIMEOUT_EN undefined: RD_WAIT waits indefinitely. err_timeout is tied 0; the port remains.

## Test plan
- Clean miss to addr 0x10, req_ready=1, resp 2 cycles after handshake with data 0xA5..A5 -> exactly one READ to 0x10; fill_valid one cycle with 0x10/0xA5..A5; miss_count=1, wb_count=0.
- Dirty miss (victim 0x20/0x1234, miss 0x30), req_ready held low 3 cycles -> WRITE 0x20 data 0x1234 held stable through the stall, then READ 0x30, then fill; wb_count=1.
- Stray resp_valid in IDLE and in WB_REQ -> no fill_valid, no state change.
- rst asserted in RD_WAIT, then resp_valid -> all outputs at reset values, no fill; next miss completes normally.
- With DCACHE_MISS_TIMEOUT_EN and RESP_TIMEOUT=4, no response -> err_timeout=1 after 4 RD_WAIT cycles and the READ is re-issued; a response then produces the fill.
- Back-to-back misses, miss_valid held high -> second miss accepted only after the first fill; miss_count=2.

Source files
------------

// File: rtl/dcache_miss_initiator.sv
// Miss initiator between dcache miss logic and the mem_ctrl block request/response port.
// Optional response timeout with read re-issue is enabled by defining DCACHE_MISS_TIMEOUT_EN.
module dcache_miss_initiator #(
    parameter int unsigned BLOCK_ADDR_W = 26,
    parameter int unsigned BLOCK_DATA_W = 512,
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss_valid,
    output logic                    miss_ready,
    input  logic [BLOCK_ADDR_W-1:0] miss_block_addr,
    input  logic                    miss_victim_dirty,
    input  logic [BLOCK_ADDR_W-1:0] miss_victim_block_addr,
    input  logic [BLOCK_DATA_W-1:0] miss_victim_block_data,
    output logic                    req_valid,
    output logic                    req_type,
    output logic [BLOCK_ADDR_W-1:0] req_block_addr,
    output logic [BLOCK_DATA_W-1:0] req_block_data,
    input  logic                    req_ready,
    input  logic                    resp_valid,
    input  logic [BLOCK_DATA_W-1:0] resp_block_data,
    output logic                    fill_valid,
    output logic [BLOCK_ADDR_W-1:0] fill_block_addr,
    output logic [BLOCK_DATA_W-1:0] fill_block_data,
    output logic                    err_timeout,
    output logic [31:0]             miss_count,
    output logic [31:0]             wb_count
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WB_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_REQ  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_FILL    = 3'd4;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    logic [2:0]              state_reg, state_next;
    logic [BLOCK_ADDR_W-1:0] miss_addr_reg;
    logic [BLOCK_ADDR_W-1:0] victim_addr_reg;
    logic [BLOCK_DATA_W-1:0] victim_data_reg;
    logic [BLOCK_DATA_W-1:0] fill_data_reg;
    logic [31:0]             miss_count_reg;
    logic [31:0]             wb_count_reg;
    logic                    err_timeout_reg;

    logic miss_accept;
    logic wb_fire;
    logic resp_take;
    logic tmo_fire;

    assign miss_accept = (state_reg == ST_IDLE) && miss_valid;
    assign wb_fire     = (state_reg == ST_WB_REQ) && req_ready;
    assign resp_take   = (state_reg == ST_RD_WAIT) && resp_valid;

`ifdef DCACHE_MISS_TIMEOUT_EN
    // Counter holds 0 outside RD_WAIT, so every entry (including a re-issue) restarts it.
    localparam int unsigned TMO_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT);
    logic [TMO_W-1:0] tmo_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst || (state_reg != ST_RD_WAIT)) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    // A response landing on the expiry cycle wins over the timeout.
    assign tmo_fire = (state_reg == ST_RD_WAIT) && !resp_valid &&
                      (tmo_cnt_reg == TMO_W'(RESP_TIMEOUT - 1));
`else
    assign tmo_fire = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (miss_valid) begin
                    state_next = miss_victim_dirty ? ST_WB_REQ : ST_RD_REQ;
                end
            end
            ST_WB_REQ: begin
                if (req_ready) begin
                    state_next = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (req_ready) begin
                    state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (resp_valid) begin
                    state_next = ST_FILL;
                end else if (tmo_fire) begin
                    state_next = ST_RD_REQ;
                end
            end
            ST_FILL: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            miss_addr_reg   <= '0;
            victim_addr_reg <= '0;
            victim_data_reg <= '0;
            fill_data_reg   <= '0;
            miss_count_reg  <= '0;
            wb_count_reg    <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (miss_accept) begin
                miss_addr_reg   <= miss_block_addr;
                victim_addr_reg <= miss_victim_block_addr;
                victim_data_reg <= miss_victim_block_data;
                if (!(&miss_count_reg)) begin
                    miss_count_reg <= miss_count_reg + 32'd1;
                end
            end
            if (wb_fire && !(&wb_count_reg)) begin
                wb_count_reg <= wb_count_reg + 32'd1;
            end
            if (resp_take) begin
                fill_data_reg <= resp_block_data;
            end
            if (tmo_fire) begin
                err_timeout_reg <= 1'b1;
            end
        end
    end

    // All handshake outputs are pure state decodes: no path from miss_valid/req_ready.
    assign miss_ready     = (state_reg == ST_IDLE) && !rst;
    assign req_valid      = (state_reg == ST_WB_REQ) || (state_reg == ST_RD_REQ);
    assign req_type       = (state_reg == ST_WB_REQ) ? REQ_WRITE : REQ_READ;
    assign req_block_addr = (state_reg == ST_WB_REQ) ? victim_addr_reg :
                            (state_reg == ST_RD_REQ) ? miss_addr_reg : '0;
    assign req_block_data = (state_reg == ST_WB_REQ) ? victim_data_reg : '0;

    assign fill_valid      = (state_reg == ST_FILL);
    assign fill_block_addr = (state_reg == ST_FILL) ? miss_addr_reg : '0;
    assign fill_block_data = (state_reg == ST_FILL) ? fill_data_reg : '0;

    assign err_timeout = err_timeout_reg;
    assign miss_count  = miss_count_reg;
    assign wb_count    = wb_count_reg;

endmodule
